// File: rtl/store_rmw_unit_pkg.sv
// Shared types and helpers for the store read-modify-write unit.
package store_rmw_unit_pkg;

  // Store operation encodings as delivered by the MEM stage.
  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_SB   = 2'b01,
    ST_SH   = 2'b10,
    ST_SW   = 2'b11
  } store_op_e;

  // Sequencer states; sw jumps straight from IDLE to WRITE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  // A halfword must sit on an even byte and a word on a multiple of four;
  // bytes can never be misaligned.
  function automatic logic is_misaligned(input store_op_e op, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (op)
      ST_SH:   bad = lane[0];
      ST_SW:   bad = (lane != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_rmw_unit_merge.sv
// Combinational lane merge: drops the store data into the selected byte or
// halfword lane of the word read from memory, mirroring the load extender.
module store_rmw_unit_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  store_op_e   op,
  input  logic [1:0]  lane,
  output logic [31:0] new_word
);

  // Replace only the addressed lane; every other bit keeps the memory value.
  always_comb begin
    new_word = old_word;
    case (op)
      ST_SB: begin
        case (lane)
          2'd0: new_word[7:0]   = wdata[7:0];
          2'd1: new_word[15:8]  = wdata[7:0];
          2'd2: new_word[23:16] = wdata[7:0];
          2'd3: new_word[31:24] = wdata[7:0];
          default: new_word = old_word;
        endcase
      end
      ST_SH: begin
        if (lane[1]) begin
          new_word[31:16] = wdata[15:0];
        end else begin
          new_word[15:0] = wdata[15:0];
        end
      end
      ST_SW:   new_word = wdata;
      default: new_word = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit for a data memory without byte enables: sw writes through,
// sb/sh read the word, merge the lane and write it back. Moore outputs only.
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        store_op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              addr_err
);

  state_e             state_q;
  state_e             state_d;
  store_op_e          op_in;
  store_op_e          op_q;
  logic [MEM_AW+1:0]  addr_q;
  logic [31:0]        data_q;
  logic [31:0]        merge_q;
  logic [31:0]        merged_word;
  logic               accept;
  logic               misaligned;
  logic               addr_err_q;
  logic               unused_addr_bits;

  assign op_in            = store_op_e'(store_op);
  assign accept           = req_valid && (state_q == S_IDLE) && (op_in != ST_NONE);
  assign misaligned       = is_misaligned(op_in, addr[1:0]);
  assign unused_addr_bits = ^addr[31:MEM_AW+2];

  store_rmw_unit_merge u_merge (
    .old_word (mem_rdata),
    .wdata    (data_q),
    .op       (op_q),
    .lane     (addr_q[1:0]),
    .new_word (merged_word)
  );

  // State register; reset abandons any operation so a pending write never issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and Moore outputs decoded from the state and latched copies.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept && !misaligned) begin
          state_d = (op_in == ST_SW) ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q[MEM_AW+1:2];
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        mem_addr = addr_q[MEM_AW+1:2];
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        mem_wr_en = 1'b1;
        done      = 1'b1;
        mem_addr  = addr_q[MEM_AW+1:2];
        mem_wdata = (op_q == ST_SW) ? data_q : merge_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the request on an aligned accept; later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= ST_NONE;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept && !misaligned) begin
      op_q   <= op_in;
      addr_q <= addr[MEM_AW+1:0];
      data_q <= wdata;
    end
  end

  // Merge register: read data arrives in WAIT and is combined with the lane there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      merge_q <= '0;
    end else if (state_q == S_WAIT) begin
      merge_q <= merged_word;
    end
  end

  // Misalignment pulse one cycle after the offending accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= accept && misaligned;
    end
  end

  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: word memory model plus a lane-arithmetic reference.
module tb_store_rmw_unit;

  localparam int MEM_AW = 10;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_SB   = 2'b01;
  localparam logic [1:0] OP_SH   = 2'b10;
  localparam logic [1:0] OP_SW   = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        store_op;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              addr_err;

  logic              pre_we;
  logic [MEM_AW-1:0] pre_addr;
  logic [31:0]       pre_data;

  logic [31:0] mem     [0:(1<<MEM_AW)-1];
  logic [31:0] ref_mem [0:15];

  int checks   = 0;
  int failures = 0;

  store_rmw_unit #(.MEM_AW(MEM_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .store_op  (store_op),
    .addr      (addr),
    .wdata     (wdata),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .done      (done),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  // Word-only data memory: one-cycle read latency, word writes, bench preload port.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (pre_we)    mem[pre_addr] <= pre_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected word after a store, from byte/halfword lane arithmetic.
  function automatic logic [31:0] model(input logic [31:0] old, input logic [1:0] op,
                                        input logic [31:0] a, input logic [31:0] d);
    int sh;
    case (op)
      OP_SW: return d;
      OP_SH: begin
        sh = int'(a[1]) * 16;
        return (old & ~(32'h0000_FFFF << sh)) | ((d & 32'h0000_FFFF) << sh);
      end
      OP_SB: begin
        sh = int'(a[1:0]) * 8;
        return (old & ~(32'h0000_00FF << sh)) | ((d & 32'h0000_00FF) << sh);
      end
      default: return old;
    endcase
  endfunction

  task automatic preload(input int w, input logic [31:0] val);
    pre_we   = 1'b1;
    pre_addr = MEM_AW'(w);
    pre_data = val;
    @(posedge clk);
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[w] = val;
  endtask

  // One request starting at a negedge; ends at the negedge of the first IDLE cycle.
  task automatic do_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    int          w;
    logic        mis;
    logic [31:0] exp_word;
    w   = int'(a[5:2]);
    mis = (op == OP_SH && a[0]) || (op == OP_SW && a[1:0] != 2'b00);
    store_op  = op;
    addr      = a;
    wdata     = d;
    req_valid = 1'b1;
    check("ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (op == OP_NONE) begin
      req_valid = 1'b0;
      check("none_rd", 32'(mem_rd_en), 32'd0);
      check("none_wr", 32'(mem_wr_en), 32'd0);
      check("none_ready", 32'(req_ready), 32'd1);
      return;
    end
    if (mis) begin
      req_valid = 1'b0;
      check("err_pulse", 32'(addr_err), 32'd1);
      check("err_rd", 32'(mem_rd_en), 32'd0);
      check("err_wr", 32'(mem_wr_en), 32'd0);
      check("err_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      check("err_pulse_end", 32'(addr_err), 32'd0);
      check("err_wr_after", 32'(mem_wr_en), 32'd0);
      return;
    end
    exp_word = model(ref_mem[w], op, a, d);
    // Busy: scramble the inputs; the unit must work from its latched copies.
    store_op = 2'($urandom_range(0, 3));
    addr     = $urandom();
    wdata    = $urandom();
    if (op != OP_SW) begin
      check("read_strobe", 32'(mem_rd_en), 32'd1);
      check("read_addr", 32'(mem_addr), 32'(w + 32'h100 * int'(a[11:6])));
      check("read_ready", 32'(req_ready), 32'd0);
      check("read_no_wr", 32'(mem_wr_en), 32'd0);
      @(negedge clk);
      check("wait_rd", 32'(mem_rd_en), 32'd0);
      check("wait_wr", 32'(mem_wr_en), 32'd0);
      check("wait_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    check("write_strobe", 32'(mem_wr_en), 32'd1);
    check("write_done", 32'(done), 32'd1);
    check("write_no_rd", 32'(mem_rd_en), 32'd0);
    check("write_addr", 32'(mem_addr), 32'(w + 32'h100 * int'(a[11:6])));
    check("write_data", mem_wdata, exp_word);
    check("write_ready", 32'(req_ready), 32'd0);
    ref_mem[w] = exp_word;
    @(negedge clk);
    req_valid = 1'b0;
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_done", 32'(done), 32'd0);
    check("idle_addr", 32'(mem_addr), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] hi;
    reset     = 1'b1;
    req_valid = 1'b0;
    store_op  = OP_NONE;
    addr      = '0;
    wdata     = '0;
    pre_we    = 1'b0;
    pre_addr  = '0;
    pre_data  = '0;
    #1;
    check("rst_rd", 32'(mem_rd_en), 32'd0);
    check("rst_wr", 32'(mem_wr_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(addr_err), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) preload(i, $urandom());

    // sw straight through
    do_store(OP_SW, 32'h0000_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    check("sw_mem", mem[4], 32'hDEAD_BEEF);

    // sb and sh read-modify-write
    preload(4, 32'h1122_3344);
    do_store(OP_SB, 32'h0000_0012, 32'h0000_00AA);
    check("sb_mem", mem[4], 32'h11AA_3344);
    preload(4, 32'h1122_3344);
    do_store(OP_SH, 32'h0000_0012, 32'h0000_BEEF);
    check("sh_hi_mem", mem[4], 32'hBEEF_3344);
    preload(4, 32'h1122_3344);
    do_store(OP_SH, 32'h0000_0010, 32'h0000_BEEF);
    check("sh_lo_mem", mem[4], 32'h1122_BEEF);

    // misaligned requests and an empty op
    do_store(OP_SH, 32'h0000_0013, 32'h1234_5678);
    do_store(OP_SW, 32'h0000_0012, 32'h1234_5678);
    do_store(OP_NONE, 32'h0000_0010, 32'h1234_5678);
    check("misaligned_mem", mem[4], 32'h1122_BEEF);

    // reset while waiting for read data
    preload(4, 32'h1122_3344);
    store_op  = OP_SB;
    addr      = 32'h0000_0012;
    wdata     = 32'h0000_00AA;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_wr", 32'(mem_wr_en), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    check("abort_wr_later", 32'(mem_wr_en), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_wr_release", 32'(mem_wr_en), 32'd0);
    check("abort_mem", mem[4], 32'h1122_3344);

    // back-to-back byte stores building a word
    preload(4, 32'h0);
    do_store(OP_SB, 32'h0000_0010, 32'h01);
    do_store(OP_SB, 32'h0000_0011, 32'h02);
    do_store(OP_SB, 32'h0000_0012, 32'h03);
    do_store(OP_SB, 32'h0000_0013, 32'h04);
    check("b2b_mem", mem[4], 32'h0403_0201);

    // random stores over words 0..15 with only aliased upper address bits set
    for (int i = 0; i < 40; i++) begin
      hi = $urandom();
      a  = (hi & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      do_store(2'($urandom_range(0, 3)), a, $urandom());
    end
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
